// File: rtl/rf_write_arbiter.sv
// Purpose : clears registers 1..NREG-1 after reset, then round-robin shares the RF write port between A and B.
// Latency : grants, write-port drive and read bypass are combinational; a write lands on the edge ending its grant cycle.
// Backpress: a requester holds req/addr/data until it sees its gnt; no grants are issued during the clear sweep.
//
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   a_req/a_wa/a_wd -> a_gnt requester A write request, address, data; grant back
//   a_ra -> a_rd             requester A read (RF port 1, with write bypass)
//   b_*                      same for requester B (RF port 2)
//   init_done                high once the clear sweep has finished
//   we3/wa3/wd3              RF write port
//   ra1/rd1, ra2/rd2         RF read ports
module rf_write_arbiter #(
   parameter int WIDTH = 32,
   parameter int AW    = 5,
   parameter int NREG  = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_req,
   input  logic [AW-1:0]    a_wa,
   input  logic [WIDTH-1:0] a_wd,
   output logic             a_gnt,
   input  logic [AW-1:0]    a_ra,
   output logic [WIDTH-1:0] a_rd,
   input  logic             b_req,
   input  logic [AW-1:0]    b_wa,
   input  logic [WIDTH-1:0] b_wd,
   output logic             b_gnt,
   input  logic [AW-1:0]    b_ra,
   output logic [WIDTH-1:0] b_rd,
   output logic             init_done,
   output logic             we3,
   output logic [AW-1:0]    wa3,
   output logic [WIDTH-1:0] wd3,
   output logic [AW-1:0]    ra1,
   output logic [AW-1:0]    ra2,
   input  logic [WIDTH-1:0] rd1,
   input  logic [WIDTH-1:0] rd2
);

   typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

   localparam logic [AW-1:0] LAST_ADDR = AW'(NREG - 1);

   state_t        state;
   state_t        state_nxt;
   logic [AW-1:0] cnt;
   logic          last_gnt;   // 0 = A was granted last, 1 = B

   // State register plus sweep counter, fairness pointer and done flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= INIT;
         cnt       <= AW'(1);
         last_gnt  <= 1'b1;   // A wins the first contended cycle
         init_done <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == INIT) begin
            cnt <= cnt + AW'(1);
            if (cnt == LAST_ADDR) begin
               init_done <= 1'b1;
            end
         end
         if (a_gnt || b_gnt) begin
            last_gnt <= b_gnt;
         end
      end
   end

   // Next-state logic: leave INIT on the cycle that clears the last register.
   always_comb begin
      state_nxt = state;
      if ((state == INIT) && (cnt == LAST_ADDR)) begin
         state_nxt = RUN;
      end
   end

   // Output logic: grants, write-port mux and bypassed read data.
   always_comb begin
      a_gnt = 1'b0;
      b_gnt = 1'b0;
      we3   = 1'b0;
      wa3   = '0;
      wd3   = '0;
      a_rd  = '0;
      b_rd  = '0;

      if (state == INIT) begin
         we3 = 1'b1;
         wa3 = cnt;
      end else begin
         // On contention, the requester that did not win last time goes now.
         a_gnt = a_req && (!b_req || last_gnt);
         b_gnt = b_req && (!a_req || !last_gnt);

         if (a_gnt) begin
            wa3 = a_wa;
            wd3 = a_wd;
            we3 = (a_wa != '0);   // address 0 is consumed but never written
         end else if (b_gnt) begin
            wa3 = b_wa;
            wd3 = b_wd;
            we3 = (b_wa != '0);
         end

         // Bypass lets a read see the value being written this cycle.
         a_rd = (we3 && (wa3 == a_ra)) ? wd3 : rd1;
         b_rd = (we3 && (wa3 == b_ra)) ? wd3 : rd2;
      end
   end

   assign ra1 = a_ra;
   assign ra2 = b_ra;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        a_req, b_req;
   logic [4:0]  a_wa, b_wa, a_ra, b_ra;
   logic [31:0] a_wd, b_wd;
   logic        a_gnt, b_gnt, init_done, we3;
   logic [4:0]  wa3, ra1, ra2;
   logic [31:0] wd3, a_rd, b_rd, rd1, rd2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   rf_write_arbiter #(.WIDTH(32), .AW(5), .NREG(32)) dut (
      .clk(clk), .reset(reset),
      .a_req(a_req), .a_wa(a_wa), .a_wd(a_wd), .a_gnt(a_gnt), .a_ra(a_ra), .a_rd(a_rd),
      .b_req(b_req), .b_wa(b_wa), .b_wd(b_wd), .b_gnt(b_gnt), .b_ra(b_ra), .b_rd(b_rd),
      .init_done(init_done), .we3(we3), .wa3(wa3), .wd3(wd3),
      .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2)
   );

   // Register file attached to the DUT; starts with garbage so the clear sweep matters.
   logic [31:0] regfile [32];
   initial begin
      for (int i = 0; i < 32; i++) regfile[i] = 32'hBAD0_0000 | 32'(i);
   end
   always @(posedge clk) begin
      if (we3) regfile[wa3] = wd3;
   end
   assign rd1 = (ra1 == 5'd0) ? 32'd0 : regfile[ra1];
   assign rd2 = (ra2 == 5'd0) ? 32'd0 : regfile[ra2];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, want %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Behavioural model: phase, sweep position, whose turn it is, register contents.
   bit          m_valid = 0;
   bit          m_init  = 1;
   bit          m_done  = 0;
   bit          m_a_turn = 1;   // A has priority on the next contended cycle
   int          m_sweep = 1;
   logic [31:0] mem [32];
   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 32'd0;
   end

   // Who the model says wins this cycle: 0 none, 1 A, 2 B.
   function automatic int winner(input bit ar, input bit br, input bit a_turn);
      if (ar && br) return a_turn ? 1 : 2;
      if (ar) return 1;
      if (br) return 2;
      return 0;
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_valid  = 1;
         m_init   = 1;
         m_done   = 0;
         m_a_turn = 1;
         m_sweep  = 1;
      end else if (m_valid) begin
         if (m_init) begin
            mem[m_sweep] = 32'd0;
            if (m_sweep == 31) begin
               m_init = 0;
               m_done = 1;
            end
            m_sweep = m_sweep + 1;
         end else begin
            case (winner(a_req, b_req, m_a_turn))
               1: begin
                  if (a_wa != 5'd0) mem[a_wa] = a_wd;
                  m_a_turn = 0;
               end
               2: begin
                  if (b_wa != 5'd0) mem[b_wa] = b_wd;
                  m_a_turn = 1;
               end
               default: ;
            endcase
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin : cmp
      logic        e_ag, e_bg, e_we;
      logic [4:0]  e_wa;
      logic [31:0] e_wd, e_ard, e_brd;
      int          w;
      if (m_valid) begin
         e_ag = 0; e_bg = 0; e_we = 0; e_wa = 5'd0; e_wd = 32'd0; e_ard = 32'd0; e_brd = 32'd0;
         if (m_init) begin
            e_we = 1;
            e_wa = 5'(m_sweep);
         end else begin
            w = winner(a_req, b_req, m_a_turn);
            if (w == 1) begin
               e_ag = 1; e_wa = a_wa; e_wd = a_wd; e_we = (a_wa != 5'd0);
            end else if (w == 2) begin
               e_bg = 1; e_wa = b_wa; e_wd = b_wd; e_we = (b_wa != 5'd0);
            end
            e_ard = (e_we && e_wa == a_ra) ? e_wd : mem[a_ra];
            e_brd = (e_we && e_wa == b_ra) ? e_wd : mem[b_ra];
         end
         chk("cmp_a_gnt", 32'(a_gnt), 32'(e_ag));
         chk("cmp_b_gnt", 32'(b_gnt), 32'(e_bg));
         chk("cmp_we3", 32'(we3), 32'(e_we));
         chk("cmp_wa3", 32'(wa3), 32'(e_wa));
         chk("cmp_wd3", wd3, e_wd);
         chk("cmp_ra1", 32'(ra1), 32'(a_ra));
         chk("cmp_ra2", 32'(ra2), 32'(b_ra));
         chk("cmp_a_rd", a_rd, e_ard);
         chk("cmp_b_rd", b_rd, e_brd);
         chk("cmp_init_done", 32'(init_done), 32'(m_done));
      end
   end

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   // Waits (bounded) for init_done; returns sweep statistics.
   task automatic wait_init(output bit seen, output int n_we, output logic [4:0] first, output logic [4:0] last);
      seen = 0; n_we = 0; first = 5'd0; last = 5'd0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (init_done) begin
            seen = 1;
            break;
         end
         if (we3) n_we++;
         if (i == 0) first = wa3;
         last = wa3;
      end
   endtask

   initial begin : stim
      bit         seen;
      int         n_we;
      logic [4:0] first, last;
      logic [7:0] pat;

      reset = 1; a_req = 0; b_req = 0;
      a_wa = 0; b_wa = 0; a_wd = 0; b_wd = 0; a_ra = 0; b_ra = 0;
      repeat (2) @(posedge clk);
      #1 reset = 0;

      // Clear sweep
      wait_init(seen, n_we, first, last);
      chk("sweep_done_seen", 32'(seen), 32'd1);
      chk("sweep_len", 32'(n_we), 32'd31);
      chk("sweep_first_wa3", 32'(first), 32'd1);
      chk("sweep_last_wa3", 32'(last), 32'd31);

      for (int i = 0; i < 32; i++) begin
         drive_edge();
         a_ra = 5'(i); b_ra = 5'(31 - i);
         @(negedge clk);
         chk("clr_a_rd", a_rd, 32'd0);
         chk("clr_b_rd", b_rd, 32'd0);
      end

      // Single write by A
      drive_edge();
      a_req = 1; a_wa = 5'd2; a_wd = 32'd12; a_ra = 0; b_ra = 0;
      @(negedge clk);
      chk("wr_a_gnt", 32'(a_gnt), 32'd1);
      chk("wr_we3", 32'(we3), 32'd1);
      chk("wr_wa3", 32'(wa3), 32'd2);
      chk("wr_wd3", wd3, 32'd12);
      drive_edge();
      a_req = 0; a_ra = 5'd2; b_ra = 5'd2;
      @(negedge clk);
      chk("rd_a_2", a_rd, 32'd12);
      chk("rd_b_2", b_rd, 32'd12);

      // B write so that A has the turn going into contention
      drive_edge();
      b_req = 1; b_wa = 5'd10; b_wd = 32'd5;
      @(negedge clk);
      chk("b_only_gnt", 32'(b_gnt), 32'd1);
      drive_edge();
      b_req = 0;

      // Contention: both held for four cycles
      a_req = 1; a_wa = 5'd3; a_wd = 32'd7;
      b_req = 1; b_wa = 5'd4; b_wd = 32'd9;
      pat = 8'd0;
      repeat (4) begin
         @(negedge clk);
         pat = {pat[5:0], a_gnt, b_gnt};
         drive_edge();
      end
      a_req = 0; b_req = 0; a_ra = 5'd3; b_ra = 5'd4;
      chk("fair_pattern", 32'(pat), 32'h99);
      @(negedge clk);
      chk("fair_a_rd3", a_rd, 32'd7);
      chk("fair_b_rd4", b_rd, 32'd9);
      chk("fair_rf3", regfile[3], 32'd7);
      chk("fair_rf4", regfile[4], 32'd9);

      // Bypass: B writes 3 while A reads 3
      drive_edge();
      b_req = 1; b_wa = 5'd3; b_wd = 32'hDEAD_BEEF; a_ra = 5'd3;
      @(negedge clk);
      chk("byp_b_gnt", 32'(b_gnt), 32'd1);
      chk("byp_a_rd", a_rd, 32'hDEAD_BEEF);
      drive_edge();
      b_req = 0;
      @(negedge clk);
      chk("byp_after_a_rd", a_rd, 32'hDEAD_BEEF);

      // Address 0 write is granted but suppressed
      drive_edge();
      a_req = 1; a_wa = 5'd0; a_wd = 32'hFFFF_FFFF; a_ra = 5'd0; b_ra = 5'd0;
      @(negedge clk);
      chk("z_a_gnt", 32'(a_gnt), 32'd1);
      chk("z_we3", 32'(we3), 32'd0);
      chk("z_a_rd", a_rd, 32'd0);
      drive_edge();
      a_req = 0;
      @(negedge clk);
      chk("z_after_a_rd", a_rd, 32'd0);
      chk("z_after_b_rd", b_rd, 32'd0);

      // Reset in the middle of RUN with both requesting
      drive_edge();
      a_req = 1; a_wa = 5'd7; a_wd = 32'd55;
      b_req = 1; b_wa = 5'd6; b_wd = 32'd66;
      a_ra = 5'd2; b_ra = 5'd7;
      @(negedge clk);
      chk("mid_pre_b_gnt", 32'(b_gnt), 32'd1);
      drive_edge();
      reset = 1;
      drive_edge();
      @(negedge clk);
      chk("mid_rst_a_gnt", 32'(a_gnt), 32'd0);
      chk("mid_rst_b_gnt", 32'(b_gnt), 32'd0);
      chk("mid_rst_wa3", 32'(wa3), 32'd1);
      chk("mid_rst_init_done", 32'(init_done), 32'd0);
      drive_edge();
      reset = 0;

      wait_init(seen, n_we, first, last);
      chk("resweep_done_seen", 32'(seen), 32'd1);
      chk("resweep_len", 32'(n_we), 32'd31);
      chk("resweep_first_wa3", 32'(first), 32'd1);
      // Held requests serviced in the first RUN cycle, A first after reset
      chk("held_a_gnt", 32'(a_gnt), 32'd1);
      chk("held_b_gnt", 32'(b_gnt), 32'd0);
      chk("held_wa3", 32'(wa3), 32'd7);
      drive_edge();
      a_req = 0;
      @(negedge clk);
      chk("held_b_gnt2", 32'(b_gnt), 32'd1);
      chk("held_wa3_2", 32'(wa3), 32'd6);
      drive_edge();
      b_req = 0;
      @(negedge clk);
      chk("post_rst_rd2", a_rd, 32'd0);
      chk("post_rst_rd7", b_rd, 32'd55);
      chk("idle_we3", 32'(we3), 32'd0);

      drive_edge();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
      $fatal(1, "watchdog");
   end

endmodule
